// File: rtl/rng_pkg.sv
// Shared definitions for the rng_arbiter slice: FSM encoding, LFSR taps,
// default seed and the shift-counter width.
package rng_pkg;

   // Arbiter FSM encoding.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      DELIVER = 2'd2
   } state_e;

   // Fibonacci taps for the 13-bit maximal-length polynomial.
   localparam int TAP_A = 12;
   localparam int TAP_B = 3;
   localparam int TAP_C = 2;
   localparam int TAP_D = 0;

   localparam logic [12:0] DEFAULT_SEED = 13'h000F;

   // Shift counter holds 0..SHIFTS_PER_DRAW-1 with SHIFTS_PER_DRAW up to 15.
   localparam int CNT_W = 4;

endpackage

// File: rtl/lfsr_core.sv
// 13-bit Fibonacci LFSR. Shifts one step per cycle while shift_en is high.
// A zero seed would lock the register at zero, so it is replaced by 1.
module lfsr_core
   import rng_pkg::*;
#(
   parameter int WIDTH = 13
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:0] lfsr_d;
   logic [WIDTH-1:0] reset_val;
   logic             feedback;

   // Next-state: shift left, feedback enters at bit 0.
   always_comb begin
      reset_val = (seed == '0) ? WIDTH'(1) : seed;
      feedback  = lfsr_q[TAP_A] ^ lfsr_q[TAP_B] ^ lfsr_q[TAP_C] ^ lfsr_q[TAP_D];
      lfsr_d    = lfsr_q;
      if (shift_en) begin
         lfsr_d = {lfsr_q[WIDTH-2:0], feedback};
      end
   end

   // LFSR register, reloaded with the seed on reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr_q <= reset_val;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign value = lfsr_q;

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one LFSR among NUM_REQ requesters.
// Each grant clocks the LFSR SHIFTS_PER_DRAW times, then delivers the
// post-shift value on rnd together with a one-cycle ack to the winner.
// Handshake: a requester raises req and holds it until its ack pulse; it
// drops req in the ack cycle if it wants no further draw. Requests dropped
// before grant are ignored; a granted draw always completes.
// Build option RNG_FREE_RUN_EN: the LFSR shifts every cycle in all states,
// so delivered values depend on request timing.
module rng_arbiter
   import rng_pkg::*;
#(
   parameter int               NUM_REQ         = 4,
   parameter int               WIDTH           = 13,
   parameter int               SHIFTS_PER_DRAW = 13,
   parameter logic [WIDTH-1:0] SEED            = DEFAULT_SEED
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] ack,
   output logic [WIDTH-1:0]   rnd,
   output logic               busy
);

   localparam int IDX_W = $clog2(NUM_REQ);

   localparam logic [1:0] ST_IDLE    = IDLE;
   localparam logic [1:0] ST_SHIFT   = SHIFT;
   localparam logic [1:0] ST_DELIVER = DELIVER;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFTS_PER_DRAW - 1);

   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   gnt_q, gnt_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [WIDTH-1:0]   rnd_q, rnd_d;

   logic               shift_en;
   logic [WIDTH-1:0]   lfsr_val;
   logic [WIDTH-1:0]   lfsr_nxt;

   // First set request at or above p, wrapping around.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [IDX_W-1:0]   p);
      logic [IDX_W-1:0] res;
      logic             found;
      int               idx;
      res   = p;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(p) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && r[idx[IDX_W-1:0]]) begin
            found = 1'b1;
            res   = IDX_W'(idx);
         end
      end
      return res;
   endfunction

   // LFSR clocking: only during SHIFT unless free-running.
   always_comb begin
`ifdef RNG_FREE_RUN_EN
      shift_en = 1'b1;
`else
      shift_en = (state_q == ST_SHIFT);
`endif
   end

   lfsr_core #(.WIDTH(WIDTH)) u_lfsr (
      .clock    (clock),
      .reset    (reset),
      .shift_en (shift_en),
      .seed     (SEED),
      .value    (lfsr_val)
   );

   // Value the LFSR takes after this cycle's shift; captured on delivery.
   always_comb begin
      lfsr_nxt = {lfsr_val[WIDTH-2:0],
                  lfsr_val[TAP_A] ^ lfsr_val[TAP_B] ^ lfsr_val[TAP_C] ^ lfsr_val[TAP_D]};
   end

   // Arbitration FSM and output register next-state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      ack_d   = ack_q;
      rnd_d   = rnd_q;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               gnt_d   = rr_pick(req, ptr_q);
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               rnd_d   = lfsr_nxt;
               ack_d   = NUM_REQ'(1) << gnt_q;
               state_d = ST_DELIVER;
            end
         end
         ST_DELIVER: begin
            ack_d   = '0;
            ptr_d   = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            ack_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any draw in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         gnt_q   <= '0;
         ptr_q   <= '0;
         ack_q   <= '0;
         rnd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         ack_q   <= ack_d;
         rnd_q   <= rnd_d;
      end
   end

   assign ack  = ack_q;
   assign rnd  = rnd_q;
   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rng_arbiter.sv
// Directed bench for rng_arbiter (default build, free-run disabled).
// Two instances: default parameters, and SHIFTS_PER_DRAW=1.
module tb_rng_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 13;
   localparam int SPD     = 13;

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_REQ-1:0] req, req1;
   logic [NUM_REQ-1:0] ack, ack1;
   logic [WIDTH-1:0]   rnd, rnd1;
   logic               busy, busy1;

   int n_pass  = 0;
   int n_total = 0;

   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] model;
   logic [WIDTH-1:0] first_draw;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   rng_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .SHIFTS_PER_DRAW(SPD),
                 .SEED(13'h000F)) dut (
      .clock(clk), .reset(rst), .req(req), .ack(ack), .rnd(rnd), .busy(busy)
   );

   rng_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .SHIFTS_PER_DRAW(1),
                 .SEED(13'h000F)) dut1 (
      .clock(clk), .reset(rst), .req(req1), .ack(ack1), .rnd(rnd1), .busy(busy1)
   );

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] l);
      return {l[11:0], l[12] ^ l[3] ^ l[2] ^ l[0]};
   endfunction

   // Scoreboard: predict the value the next grant will deliver.
   task automatic predict_draw();
      for (int i = 0; i < SPD; i++) model = lfsr_step(model);
      exp_q.push_back(model);
   endtask

   // ---------------- drivers ----------------
   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      req  = '0;
      req1 = '0;
      @(negedge clk);
      @(negedge clk);
      rst  = 1'b0;
      model = 13'h000F;
      exp_q.delete();
   endtask

   // Wait for an ack on the default instance; check one-hot and the value.
   task automatic wait_ack(input string tag, input int budget, output logic [NUM_REQ-1:0] got);
      int cyc;
      logic [WIDTH-1:0] e;
      cyc = 0;
      got = '0;
      while (cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (ack != '0) begin
            got = ack;
            break;
         end
      end
      chk({tag, "_seen"}, 32'(got != '0), 32'd1);
      if (got != '0) begin
         chk({tag, "_onehot"}, 32'($onehot(ack)), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_rnd"}, 32'(rnd), 32'(e));
         end
      end
   endtask

   // ---------------- stimulus ----------------
   logic [WIDTH-1:0]   t1_exp [4];
   logic [NUM_REQ-1:0] t3_exp [5];
   logic [NUM_REQ-1:0] t4_exp [3];
   logic [NUM_REQ-1:0] got;
   int                 cyc, busy_cnt, ack_at, ack1_cnt;

   initial begin
      t1_exp = '{13'h001F, 13'h003F, 13'h007F, 13'h00FF};
      t3_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      t4_exp = '{4'b0010, 4'b1000, 4'b0010};
      rst  = 1'b1;
      req  = '0;
      req1 = '0;
      do_reset();

      // reset state
      chk("rst_ack",  32'(ack),  32'd0);
      chk("rst_rnd",  32'(rnd),  32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ack1", 32'(ack1), 32'd0);

      // SHIFTS_PER_DRAW=1, req[0] held for 4 draws
      req1 = 4'b0001;
      for (int d = 0; d < 4; d++) begin
         cyc = 0;
         while (ack1 == '0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
         end
         chk($sformatf("spd1_ack_%0d", d), 32'(ack1), 32'd1);
         chk($sformatf("spd1_rnd_%0d", d), 32'(rnd1), 32'(t1_exp[d]));
         if (d == 3) req1 = '0;
         @(negedge clk);
         chk($sformatf("spd1_pulse_%0d", d), 32'(ack1), 32'd0);
      end

      // Default parameters, single req[0]: latency and busy width
      do_reset();
      predict_draw();
      first_draw = model;
      req = 4'b0001;
      busy_cnt = 0;
      ack_at   = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (ack != '0 && ack_at == 0) begin
            ack_at = k;
            req = '0;
            chk("lat_ack", 32'(ack), 32'd1);
            chk("lat_rnd", 32'(rnd), 32'(exp_q.pop_front()));
         end
      end
      chk("lat_cycles", 32'(ack_at), 32'd14);
      chk("lat_busy", 32'(busy_cnt), 32'd14);
      chk("lat_idle", 32'(busy), 32'd0);
      chk("lat_rnd_held", 32'(rnd), 32'(first_draw));

      // All four requesting: round-robin from 0
      do_reset();
      req = 4'b1111;
      for (int d = 0; d < 5; d++) begin
         predict_draw();
         wait_ack($sformatf("rr4_%0d", d), 40, got);
         chk($sformatf("rr4_ack_%0d", d), 32'(got), 32'(t3_exp[d]));
         if (d == 4) req = '0;
      end
      repeat (3) @(negedge clk);

      // req=1010 with ptr=0
      do_reset();
      req = 4'b1010;
      for (int d = 0; d < 3; d++) begin
         predict_draw();
         wait_ack($sformatf("rr2_%0d", d), 40, got);
         chk($sformatf("rr2_ack_%0d", d), 32'(got), 32'(t4_exp[d]));
         if (d == 2) req = '0;
      end
      repeat (3) @(negedge clk);

      // Reset mid-SHIFT, then a fresh draw from req[2]
      do_reset();
      req = 4'b0001;
      repeat (5) @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      chk("mid_rst_ack",  32'(ack),  32'd0);
      chk("mid_rst_rnd",  32'(rnd),  32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_state", 32'(dut.state_q), 32'd0);
      rst = 1'b0;
      model = 13'h000F;
      exp_q.delete();
      predict_draw();
      req = 4'b0100;
      wait_ack("post_rst", 40, got);
      req = '0;
      chk("post_rst_ack", 32'(got), 32'b0100);
      chk("post_rst_same", 32'(rnd), 32'(first_draw));
      repeat (3) @(negedge clk);

      // req[1] pulsed while busy on req[0]'s draw: never acked
      do_reset();
      predict_draw();
      req = 4'b0001;
      repeat (3) @(negedge clk);
      req = 4'b0011;
      @(negedge clk);
      req = 4'b0001;
      wait_ack("pulse", 40, got);
      req = '0;
      chk("pulse_ack0", 32'(got), 32'd1);
      ack1_cnt = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (ack[1]) ack1_cnt++;
      end
      chk("pulse_no_ack1", 32'(ack1_cnt), 32'd0);
      chk("pulse_idle", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
